// File: rtl/mazegen_pkg.sv
// Shared types and constants for the random maze generator.
package mazegen_pkg;

  typedef enum logic [1:0] {
    DIR_N = 2'd0,
    DIR_E = 2'd1,
    DIR_S = 2'd2,
    DIR_W = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_LOOK  = 2'd1,
    ST_CARVE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [15:0] LFSR_MASK     = 16'hB400;
  localparam logic [15:0] LFSR_ZERO_SUB = 16'hACE1;

endpackage

// File: rtl/mazegen_lfsr.sv
// 16-bit Galois LFSR; the seed is loaded asynchronously while rst is high.
module mazegen_lfsr
  import mazegen_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] seed,
  input  logic        en,
  output logic [15:0] q
);

  // An all-zero state would lock up the register, so it is substituted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= (seed == 16'h0000) ? LFSR_ZERO_SUB : seed;
    end else if (en) begin
      q <= {1'b0, q[15:1]} ^ (q[0] ? LFSR_MASK : 16'h0000);
    end
  end

endmodule

// File: rtl/mazegen.sv
// Randomized depth-first backtracker carving a perfect maze into a size x size bit grid.
module mazegen
  import mazegen_pkg::*;
#(
  parameter int size = 15,
  parameter int N    = $clog2(size)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [15:0]     seed,
  output logic            done,
  output logic [size-1:0] maze [size]
);

  localparam int C     = (size + 1) / 2;
  localparam int DEPTH = C * C;
  localparam int AW    = $clog2(DEPTH);
  localparam int SPW   = $clog2(DEPTH + 1);

  localparam logic [N:0]     LIM    = (N+1)'(size - 1);
  localparam logic [N:0]     TWO_W  = (N+1)'(2);
  localparam logic [N-1:0]   ONE    = N'(1);
  localparam logic [N-1:0]   TWO    = N'(2);
  localparam logic [SPW-1:0] SP_ONE = SPW'(1);

  state_t           state;
  state_t           state_nxt;
  logic [15:0]      lfsr_q;
  logic             lfsr_en;
  logic             do_start;
  logic             do_sel;
  logic             do_pop;
  logic             do_carve;
  logic             do_done;
  dir_t             dir_r;
  logic [SPW-1:0]   sp;
  logic [SPW-1:0]   sp_m1;
  logic [2*N-1:0]   stack [DEPTH];
  logic [N-1:0]     top_x;
  logic [N-1:0]     top_y;
  logic [N-1:0]     nx;
  logic [N-1:0]     ny;
  logic [N-1:0]     mx;
  logic [N-1:0]     my;
  logic [3:0]       nb_mask;

  // First set bit of mask, scanning upward (mod 4) from the random start.
  function automatic dir_t pick_dir(input logic [3:0] mask, input logic [1:0] start);
    logic [1:0] d;
    pick_dir = dir_t'(start);
    for (int i = 3; i >= 0; i--) begin
      d = start + 2'(i);
      if (mask[d]) pick_dir = dir_t'(d);
    end
  endfunction

  mazegen_lfsr u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .seed (seed),
    .en   (lfsr_en),
    .q    (lfsr_q)
  );

  assign sp_m1          = sp - SP_ONE;
  assign {top_y, top_x} = stack[sp_m1[AW-1:0]];

  // Bounds use one extra bit so edges never wrap into the opposite side.
  always_comb begin
    nb_mask = 4'b0000;
    if ({1'b0, top_y} >= TWO_W)
      nb_mask[DIR_N] = ~maze[top_y - TWO][top_x];
    if ({1'b0, top_x} + TWO_W <= LIM)
      nb_mask[DIR_E] = ~maze[top_y][top_x + TWO];
    if ({1'b0, top_y} + TWO_W <= LIM)
      nb_mask[DIR_S] = ~maze[top_y + TWO][top_x];
    if ({1'b0, top_x} >= TWO_W)
      nb_mask[DIR_W] = ~maze[top_y][top_x - TWO];
  end

  always_comb begin
    nx = top_x;
    ny = top_y;
    mx = top_x;
    my = top_y;
    case (dir_r)
      DIR_N:   begin ny = top_y - TWO; my = top_y - ONE; end
      DIR_E:   begin nx = top_x + TWO; mx = top_x + ONE; end
      DIR_S:   begin ny = top_y + TWO; my = top_y + ONE; end
      default: begin nx = top_x - TWO; mx = top_x - ONE; end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_START;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_START: state_nxt = ST_LOOK;
      ST_LOOK: begin
        if (nb_mask != 4'b0000)  state_nxt = ST_CARVE;
        else if (sp == SP_ONE)   state_nxt = ST_DONE;
      end
      ST_CARVE: state_nxt = ST_LOOK;
      ST_DONE:  state_nxt = ST_DONE;
      default:  state_nxt = ST_START;
    endcase
  end

  always_comb begin
    do_start = (state == ST_START);
    lfsr_en  = (state == ST_LOOK);
    do_sel   = (state == ST_LOOK) && (nb_mask != 4'b0000);
    do_pop   = (state == ST_LOOK) && (nb_mask == 4'b0000);
    do_carve = (state == ST_CARVE);
    do_done  = (state == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < size; i++) maze[i] <= '0;
      sp    <= '0;
      dir_r <= DIR_N;
      done  <= 1'b0;
    end else begin
      if (do_start) begin
        maze[0][0] <= 1'b1;
        sp         <= SP_ONE;
      end
      if (do_pop) sp <= sp_m1;
      if (do_sel) dir_r <= pick_dir(nb_mask, lfsr_q[1:0]);
      if (do_carve) begin
        maze[my][mx] <= 1'b1;
        maze[ny][nx] <= 1'b1;
        sp           <= sp + SP_ONE;
      end
      if (do_done) done <= 1'b1;
    end
  end

  // Stack contents need no reset; sp alone defines what is valid.
  always_ff @(posedge clk) begin
    if (do_start)      stack[0] <= '0;
    else if (do_carve) stack[sp[AW-1:0]] <= {ny, nx};
  end

endmodule

// File: tb/tb_mazegen.sv
// Directed bench for mazegen: latency, structure, and row-exact compare against a behavioural model.
module tb_mazegen;

  logic        clk;
  logic        rst;
  logic [15:0] seed;
  logic        done;
  logic [14:0] maze [15];

  logic        rst5;
  logic [15:0] seed5;
  logic        done5;
  logic [4:0]  maze5 [5];

  logic [14:0] exp_rows [15];
  logic [14:0] ref1234  [15];

  int n_checks = 0;
  int n_fail   = 0;
  int lat;

  mazegen #(.size(15)) dut (
    .clk  (clk),
    .rst  (rst),
    .seed (seed),
    .done (done),
    .maze (maze)
  );

  mazegen #(.size(5)) dut5 (
    .clk  (clk),
    .rst  (rst5),
    .seed (seed5),
    .done (done5),
    .maze (maze5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference generator: randomized DFS over the grid, one LFSR step per stack inspection.
  task automatic model(input logic [15:0] sd, input int sz);
    logic [15:0] lf;
    int          sx [64];
    int          sy [64];
    int          sp, x, y, d, nx, ny, st;
    logic [3:0]  m;
    lf = (sd == 16'h0000) ? 16'hACE1 : sd;
    for (int i = 0; i < 15; i++) exp_rows[i] = '0;
    exp_rows[0][0] = 1'b1;
    sx[0] = 0; sy[0] = 0; sp = 1;
    while (sp > 0) begin
      x = sx[sp-1];
      y = sy[sp-1];
      m = 4'b0000;
      if (y - 2 >= 0) m[0] = !exp_rows[y-2][x];
      if (x + 2 < sz) m[1] = !exp_rows[y][x+2];
      if (y + 2 < sz) m[2] = !exp_rows[y+2][x];
      if (x - 2 >= 0) m[3] = !exp_rows[y][x-2];
      st = int'(lf[1:0]);
      lf = {1'b0, lf[15:1]} ^ (lf[0] ? 16'hB400 : 16'h0000);
      if (m == 4'b0000) begin
        sp--;
      end else begin
        d = -1;
        for (int i = 0; i < 4; i++)
          if (d < 0 && m[(st + i) % 4]) d = (st + i) % 4;
        nx = x; ny = y;
        case (d)
          0:       ny = y - 2;
          1:       nx = x + 2;
          2:       ny = y + 2;
          default: nx = x - 2;
        endcase
        exp_rows[(y + ny) / 2][(x + nx) / 2] = 1'b1;
        exp_rows[ny][nx] = 1'b1;
        sx[sp] = nx; sy[sp] = ny;
        sp++;
      end
    end
  endtask

  task automatic wait_done15(output int l);
    l = -1;
    for (int c = 1; c <= 400; c++) begin
      @(posedge clk); #1;
      if (done) begin l = c; break; end
    end
  endtask

  task automatic wait_done5(output int l);
    l = -1;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      if (done5) begin l = c; break; end
    end
  endtask

  task automatic cmp_rows15(input string tag);
    for (int i = 0; i < 15; i++)
      check($sformatf("%s_row%0d", tag, i), 32'(maze[i]), 32'(exp_rows[i]));
  endtask

  task automatic restart15(input logic [15:0] s);
    @(negedge clk);
    seed = s;
    rst  = 1'b1;
    @(negedge clk);
    rst  = 1'b0;
  endtask

  task automatic struct15(input string tag);
    int   ee, oo, pop, reach, c, cx, cy, ax, ay, bx, by;
    int   q[$];
    bit   vis [15][15];
    ee = 0; oo = 0; pop = 0; reach = 0;
    for (int y = 0; y < 15; y++)
      for (int x = 0; x < 15; x++) begin
        vis[y][x] = 1'b0;
        if (maze[y][x]) begin
          pop++;
          if (x % 2 == 0 && y % 2 == 0) ee++;
          if (x % 2 == 1 && y % 2 == 1) oo++;
        end
      end
    vis[0][0] = 1'b1;
    q.push_back(0);
    while (q.size() > 0) begin
      c = q.pop_front();
      reach++;
      cy = c / 15; cx = c % 15;
      for (int d = 0; d < 4; d++) begin
        ax = cx; ay = cy; bx = cx; by = cy;
        case (d)
          0:       begin ay = cy - 1; by = cy - 2; end
          1:       begin ax = cx + 1; bx = cx + 2; end
          2:       begin ay = cy + 1; by = cy + 2; end
          default: begin ax = cx - 1; bx = cx - 2; end
        endcase
        if (bx >= 0 && bx < 15 && by >= 0 && by < 15) begin
          if (maze[ay][ax] && maze[by][bx] && !vis[by][bx]) begin
            vis[by][bx] = 1'b1;
            q.push_back(by * 15 + bx);
          end
        end
      end
    end
    check({tag, "_cells"},  32'(ee),    32'd64);
    check({tag, "_oddodd"}, 32'(oo),    32'd0);
    check({tag, "_pop"},    32'(pop),   32'd127);
    check({tag, "_reach"},  32'(reach), 32'd64);
  endtask

  initial begin
    int any;
    int ndiff;
    int pop5;
    int bad;

    rst   = 1'b1;
    rst5  = 1'b1;
    seed  = 16'h1234;
    seed5 = 16'h1234;
    repeat (2) @(negedge clk);
    any = 0;
    for (int i = 0; i < 15; i++) if (maze[i] != '0) any++;
    check("rst_done", 32'(done), 32'd0);
    check("rst_maze", 32'(any),  32'd0);

    // Clean run, seed 1234
    @(negedge clk);
    rst = 1'b0;
    wait_done15(lat);
    check("lat_1234", 32'(lat), 32'd192);
    model(16'h1234, 15);
    for (int i = 0; i < 15; i++) ref1234[i] = exp_rows[i];
    cmp_rows15("s1234");
    struct15("s1234");
    repeat (5) @(posedge clk);
    #1;
    check("done_held", 32'(done), 32'd1);

    // Different seed gives a different but equally valid maze
    restart15(16'hBEEF);
    wait_done15(lat);
    check("lat_beef", 32'(lat), 32'd192);
    model(16'hBEEF, 15);
    cmp_rows15("sbeef");
    struct15("sbeef");
    ndiff = 0;
    for (int i = 0; i < 15; i++) if (maze[i] != ref1234[i]) ndiff++;
    check("beef_differs", 32'(ndiff != 0), 32'd1);

    // Zero seed is replaced by ACE1
    restart15(16'h0000);
    wait_done15(lat);
    check("lat_zero", 32'(lat), 32'd192);
    model(16'hACE1, 15);
    cmp_rows15("szero");

    // Asynchronous reset mid-generation
    restart15(16'h1234);
    repeat (50) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    any = 0;
    for (int i = 0; i < 15; i++) if (maze[i] != '0) any++;
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_maze", 32'(any),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    wait_done15(lat);
    check("lat_regen", 32'(lat), 32'd192);
    for (int i = 0; i < 15; i++) exp_rows[i] = ref1234[i];
    cmp_rows15("regen");

    // Smallest grid
    @(negedge clk);
    seed5 = 16'h1234;
    rst5  = 1'b1;
    @(negedge clk);
    rst5  = 1'b0;
    wait_done5(lat);
    check("lat_s5", 32'(lat), 32'd27);
    pop5 = 0;
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 5; x++) if (maze5[y][x]) pop5++;
    check("pop_s5", 32'(pop5), 32'd17);
    model(16'h1234, 5);
    for (int i = 0; i < 5; i++)
      check($sformatf("s5_row%0d", i), 32'(maze5[i]), 32'(exp_rows[i][4:0]));
    bad = 0;
    for (int c = 0; c < 1000; c++) begin
      @(posedge clk); #1;
      if (done5 !== 1'b1) bad++;
      for (int i = 0; i < 5; i++) if (maze5[i] !== exp_rows[i][4:0]) bad++;
    end
    check("s5_hold", 32'(bad), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
